// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU (port 0) and LSU (port 1) with round-robin
// arbitration, one outstanding transaction, and a watchdog that forces an error response.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // Counter only ever reaches TIMEOUT-1 before WAIT is left.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic             owner;       // 0 = IFU, 1 = LSU
  logic             last_grant;  // port granted most recently
  logic [CNT_W-1:0] wdog;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             wdog_expired;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_ifu     = ifu_req_valid & (~lsu_req_valid | last_grant);
    grant_lsu     = lsu_req_valid & (~ifu_req_valid | ~last_grant);
    ifu_req_ready = (state == IDLE) & grant_ifu;
    lsu_req_ready = (state == IDLE) & grant_lsu;
    wdog_expired  = (wdog == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      wdog           <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ifu | grant_lsu) begin
            owner         <= grant_lsu;
            last_grant    <= grant_lsu;
            mem_req_valid <= 1'b1;
            state         <= REQ;
            if (grant_lsu) begin
              mem_addr  <= lsu_addr;
              mem_wen   <= lsu_wen;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end else begin
              mem_addr  <= ifu_addr;
              mem_wen   <= 1'b0;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wdog          <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          wdog <= wdog + CNT_W'(1);
          // A response in the same cycle as expiry takes priority over the error.
          if (mem_resp_valid || wdog_expired) begin
            state          <= RESP;
            ifu_resp_valid <= ~owner;
            lsu_resp_valid <= owner;
            ifu_resp_err   <= ~owner & ~mem_resp_valid;
            lsu_resp_err   <= owner & ~mem_resp_valid;
            resp_rdata     <= mem_resp_valid ? mem_rdata : '0;
          end
        end
        RESP: begin
          ifu_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
          ifu_resp_err   <= 1'b0;
          lsu_resp_err   <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
